// File: rtl/demux_rr_dispatcher_if.sv
// rtl/demux_rr_dispatcher_if.sv - stream bundle between the dispatcher and its source/sinks
// master: upstream source plus downstream ready; slave: the dispatcher itself.
interface demux_rr_dispatcher_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic [7:0]        out_valid;
  logic [7:0]        out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/demux_rr_dispatcher.sv
// rtl/demux_rr_dispatcher.sv - round-robin burst dispatcher driving a 1-to-8 demux select
// Optional per-channel enable mask: define DEMUX_MASK_EN to add the chan_en port.
module demux_rr_dispatcher #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  demux_rr_dispatcher_if.slave   bus,
`ifdef DEMUX_MASK_EN
  input  logic [7:0]             chan_en,
`endif
  output logic [2:0]             cur_sel,
  output logic                   busy
);
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t           state_q, state_d;
  logic [2:0]       cur_sel_q, cur_sel_d;
  logic [2:0]       last_grant_q, last_grant_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             busy_q, busy_d;

  logic [7:0] en_mask;
  logic [7:0] elig;
  logic [2:0] grant;
  logic [2:0] cand;
  logic       grant_found;
  logic       xfer_last;
  logic       hs;

`ifdef DEMUX_MASK_EN
  assign en_mask = chan_en;
`else
  assign en_mask = 8'hFF;
`endif

  assign elig = bus.out_ready & en_mask;

  // Search starts one past the last finished grant; i=8 wraps back onto last_grant itself.
  always_comb begin
    grant       = last_grant_q;
    grant_found = 1'b0;
    cand        = '0;
    for (int i = 1; i <= 8; i++) begin
      cand = last_grant_q + 3'(i);
      if (!grant_found && elig[cand]) begin
        grant       = cand;
        grant_found = 1'b1;
      end
    end
  end

  assign xfer_last = bus.in_last | (beat_cnt_q == LAST_BEAT);

  always_comb begin
    bus.out_valid = '0;
    bus.in_ready  = 1'b0;
    bus.out_last  = 1'b0;
    if (state_q == XFER) begin
      bus.out_valid[cur_sel_q] = bus.in_valid;
      bus.in_ready             = bus.out_ready[cur_sel_q];
      bus.out_last             = xfer_last;
    end
  end

  assign bus.out_data = bus.in_data;
  assign hs           = bus.in_valid & bus.in_ready;

  always_comb begin
    state_d      = state_q;
    cur_sel_d    = cur_sel_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    busy_d       = busy_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && grant_found) begin
          cur_sel_d  = grant;
          beat_cnt_d = '0;
          busy_d     = 1'b1;
          state_d    = XFER;
        end
      end
      XFER: begin
        if (hs) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (xfer_last) begin
            last_grant_d = cur_sel_q;
            busy_d       = 1'b0;
            state_d      = IDLE;
          end
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cur_sel_q    <= 3'd0;
      last_grant_q <= 3'd7;
      beat_cnt_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_sel_q    <= cur_sel_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      busy_q       <= busy_d;
    end
  end

  assign cur_sel = cur_sel_q;
  assign busy    = busy_q;
endmodule
